game_timer: RTL and testbench

- Parametrised, prescaled second timer for the game flow. It supersedes the single-purpose 20-second/free-running counter pair.
- One instance supports three modes:
  - free-running up-count (on-going game clock),
  - up-to-limit with done flag,
  - countdown from limit with done flag.
- Also provides pause/resume, clear, and a per-tick strobe.
- Sits between the top control FSM (Start/Enable/Clear, countDone) and the HEX display and equation blocks (Timer).

---
 rtl/game_timer.sv | 182 ++++++++++++++++++
 tb/tb_game_timer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// Prescaled game timer: free-run up, up-to-LIMIT and countdown-from-LIMIT modes with pause/clear.
// Optional GAME_TIMER_BCD_OUT_EN adds a registered, saturating two-digit BCD copy of the count.
module game_timer #(
    parameter int WIDTH    = 7,
    parameter int TICK_DIV = 50000000,
    parameter int LIMIT    = 20
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic             i_Enable,
    input  logic             i_Clear,
    input  logic [1:0]       i_Mode,
    output logic [WIDTH-1:0] o_Timer,
    output logic             o_TickPulse,
    output logic             o_countDone,
    output logic             o_DonePulse,
    output logic             o_Running
`ifdef GAME_TIMER_BCD_OUT_EN
    ,
    output logic [7:0]       o_TimerBCD
`endif
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] LIMIT_V   = WIDTH'(LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nxt;
    logic [WIDTH-1:0] r_timer;
    logic [WIDTH-1:0] w_timer_nxt;
    logic [1:0]       r_mode;
    logic [1:0]       w_mode_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_done_pulse;
    logic             w_done_pulse_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_running;

    logic             w_mode_limit;
    logic             w_mode_down;
    logic [WIDTH-1:0] w_timer_step;
    logic             w_terminal;

`ifdef GAME_TIMER_BCD_OUT_EN
    logic [7:0]       r_bcd;

    function automatic logic [7:0] f_bcd_sat(input logic [WIDTH-1:0] v);
        int unsigned val;
        logic [3:0]  tens;
        logic [3:0]  ones;
        val = 32'(v);
        if (val >= 32'd100) begin
            return 8'h99;
        end
        tens = 4'(val / 32'd10);
        ones = 4'(val % 32'd10);
        return {tens, ones};
    endfunction
`endif

    // Mode 11 falls through to the free-running up-count.
    assign w_mode_limit = (r_mode == 2'b01);
    assign w_mode_down  = (r_mode == 2'b10);
    assign w_timer_step = w_mode_down ? (r_timer - WIDTH'(1)) : (r_timer + WIDTH'(1));
    assign w_terminal   = (w_mode_limit && (w_timer_step == LIMIT_V)) ||
                          (w_mode_down  && (w_timer_step == '0));

    always_comb begin
        w_state_nxt      = r_state;
        w_presc_nxt      = r_presc;
        w_timer_nxt      = r_timer;
        w_mode_nxt       = r_mode;
        w_done_nxt       = r_done;
        w_done_pulse_nxt = 1'b0;
        w_tick_nxt       = 1'b0;

        if (i_Clear) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_timer_nxt = '0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_Start) begin
                        w_state_nxt = S_RUN;
                        w_mode_nxt  = i_Mode;
                        w_presc_nxt = '0;
                        w_timer_nxt = (i_Mode == 2'b10) ? LIMIT_V : '0;
                        w_done_nxt  = 1'b0;
                    end
                end
                S_RUN: begin
                    // A falling Enable beats a coincident tick.
                    if (!i_Enable) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_presc == PRESC_MAX) begin
                        w_presc_nxt = '0;
                        w_tick_nxt  = 1'b1;
                        w_timer_nxt = w_timer_step;
                        if (w_terminal) begin
                            w_state_nxt      = S_DONE;
                            w_done_nxt       = 1'b1;
                            w_done_pulse_nxt = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (i_Enable) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers are loaded from next-state values so they line up with r_state.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            r_presc      <= '0;
            r_timer      <= '0;
            r_mode       <= 2'b00;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_timer      <= w_timer_nxt;
            r_mode       <= w_mode_nxt;
            r_done       <= w_done_nxt;
            r_done_pulse <= w_done_pulse_nxt;
            r_tick       <= w_tick_nxt;
            r_running    <= (w_state_nxt == S_RUN);
        end
    end

`ifdef GAME_TIMER_BCD_OUT_EN
    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            r_bcd <= 8'h00;
        end else begin
            r_bcd <= f_bcd_sat(w_timer_nxt);
        end
    end

    assign o_TimerBCD = r_bcd;
`endif

    assign o_Timer     = r_timer;
    assign o_TickPulse = r_tick;
    assign o_countDone = r_done;
    assign o_DonePulse = r_done_pulse;
    assign o_Running   = r_running;

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: driver pushes per-cycle expectations from a behavioural model,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_timer;

    localparam int W   = 7;
    localparam int TD  = 4;
    localparam int LIM = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         start;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] timer;
    logic         tick;
    logic         cdone;
    logic         dpulse;
    logic         running;
`ifdef GAME_TIMER_BCD_OUT_EN
    logic [7:0]   bcd;
`endif

    always #5 clk = ~clk;

    game_timer #(.WIDTH(W), .TICK_DIV(TD), .LIMIT(LIM)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst_n),
        .i_Start     (start),
        .i_Enable    (en),
        .i_Clear     (clr),
        .i_Mode      (mode),
        .o_Timer     (timer),
        .o_TickPulse (tick),
        .o_countDone (cdone),
        .o_DonePulse (dpulse),
        .o_Running   (running)
`ifdef GAME_TIMER_BCD_OUT_EN
        ,
        .o_TimerBCD  (bcd)
`endif
    );

    typedef struct {
        int timer;
        int tick;
        int done;
        int dpulse;
        int run;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    // Reference model: "active" covers running or paused, "finished" is the sticky done flag.
    bit m_active;
    bit m_paused;
    bit m_finished;
    int m_timer;
    int m_phase;
    int m_mode;

    task automatic model_step(input bit r, input bit c, input bit s, input bit e,
                              input int md, output exp_t x);
        int tk;
        int dp;
        tk = 0;
        dp = 0;
        if (!r || c) begin
            m_active   = 0;
            m_paused   = 0;
            m_finished = 0;
            m_timer    = 0;
            m_phase    = 0;
            if (!r) m_mode = 0;
        end else if (s && !m_active) begin
            m_active   = 1;
            m_paused   = 0;
            m_finished = 0;
            m_mode     = md;
            m_phase    = 0;
            m_timer    = (md == 2) ? LIM : 0;
        end else if (m_active && m_paused) begin
            if (e) m_paused = 0;
        end else if (m_active) begin
            if (!e) begin
                m_paused = 1;
            end else begin
                m_phase++;
                if (m_phase == TD) begin
                    m_phase = 0;
                    tk = 1;
                    if (m_mode == 2) m_timer = m_timer - 1;
                    else             m_timer = (m_timer + 1) % (1 << W);
                    if ((m_mode == 1 && m_timer == LIM) || (m_mode == 2 && m_timer == 0)) begin
                        m_active   = 0;
                        m_finished = 1;
                        dp = 1;
                    end
                end
            end
        end
        x.timer  = m_timer;
        x.tick   = tk;
        x.done   = m_finished ? 1 : 0;
        x.dpulse = dp;
        x.run    = (m_active && !m_paused) ? 1 : 0;
        x.cyc    = cyc_n;
    endtask

    task automatic chk(input string name, input int got, input int expv, input int cyc);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, expv);
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit s, input bit e, input int md);
        exp_t x;
        rst_n = r;
        clr   = c;
        start = s;
        en    = e;
        mode  = 2'(md);
        model_step(r, c, s, e, md, x);
        @(posedge clk);
        q.push_back(x);
        cyc_n++;
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_x = q.pop_front();
            chk("Timer",     int'(timer),   mon_x.timer,  mon_x.cyc);
            chk("TickPulse", int'(tick),    mon_x.tick,   mon_x.cyc);
            chk("countDone", int'(cdone),   mon_x.done,   mon_x.cyc);
            chk("DonePulse", int'(dpulse),  mon_x.dpulse, mon_x.cyc);
            chk("Running",   int'(running), mon_x.run,    mon_x.cyc);
`ifdef GAME_TIMER_BCD_OUT_EN
            chk("TimerBCD", int'(bcd),
                (mon_x.timer >= 100) ? 'h99 : ((mon_x.timer / 10) * 16 + (mon_x.timer % 10)),
                mon_x.cyc);
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;

        repeat (3) cyc(0, 0, 0, 0, 0);

        // Reset mid-run at Timer=9 in mode 01, Start held during reset.
        cyc(1, 0, 1, 1, 1);
        repeat (36) cyc(1, 0, 0, 1, 1);
        repeat (2)  cyc(0, 0, 1, 1, 1);
        repeat (3)  cyc(1, 0, 0, 1, 1);

        // Mode 01 to LIMIT, then idle in DONE.
        cyc(1, 0, 1, 1, 1);
        repeat (100) cyc(1, 0, 0, 1, 1);

        // Clear and Start together in DONE, then countdown to zero.
        cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 1, 1, 2);
        repeat (92) cyc(1, 0, 0, 1, 2);

        // Pause at Timer=5 after two prescaler counts.
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 1, 1, 1);
        repeat (22) cyc(1, 0, 0, 1, 1);
        repeat (10) cyc(1, 0, 0, 0, 1);
        repeat (8)  cyc(1, 0, 0, 1, 1);

        // Free-run wrap, then mode 11 behaving as free-run.
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 1, 1, 0);
        repeat (530) cyc(1, 0, 0, 1, 2);
        cyc(1, 1, 0, 1, 0);
        cyc(1, 0, 1, 1, 3);
        repeat (20) cyc(1, 0, 0, 1, 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            cyc((r < 3) ? 1'b0 : 1'b1,
                (r >= 3 && r < 10) ? 1'b1 : 1'b0,
                ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                int'($urandom_range(0, 3)));
        end

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
